// File: rtl/tx_burst_sequencer_if.sv
// rtl/tx_burst_sequencer_if.sv - payload symbol stream between symbol source and burst sequencer
interface tx_burst_sequencer_if;
  logic sym_data;
  logic sym_valid;
  logic sym_ready;

  modport master (output sym_data, output sym_valid, input sym_ready);
  modport slave  (input sym_data, input sym_valid, output sym_ready);
endinterface

// File: rtl/tx_burst_sequencer.sv
// rtl/tx_burst_sequencer.sv - GMSK burst sequencer: prime, arm, ramp-up, payload, ramp-down, guard
// Optional underrun fill from an 8-bit Galois LFSR: define TX_BURST_SEQ_LFSR_FILL_EN.
module tx_burst_sequencer #(
  parameter int IQ_W       = 9,
  parameter int MASK_W     = 8,
  parameter int RAMP_LEN   = 256,
  parameter int PRIME_SYMS = 4,
  parameter int GUARD_LEN  = 1020,
  localparam int ADDR_W    = $clog2(RAMP_LEN)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     symbol_input_strobe,
  output logic                     current_symbol_o,
  input  logic signed [IQ_W-1:0]   modulator_inphase,
  input  logic signed [IQ_W-1:0]   modulator_quadrature,
  output logic signed [IQ_W-1:0]   rfchain_inphase,
  output logic signed [IQ_W-1:0]   rfchain_quadrature,
  output logic                     iq_valid,
  output logic [ADDR_W-1:0]        ramp_addr,
  input  logic [MASK_W-1:0]        ramp_coef,
  tx_burst_sequencer_if.slave      sym,
  input  logic [7:0]               burst_len,
  input  logic                     fire_burst,
  output logic                     is_armed,
  output logic                     underrun
);

  localparam int CNT_W = $clog2((GUARD_LEN > 256 ? GUARD_LEN : 256) + 1);
  localparam int PW    = IQ_W + MASK_W + 1;

  typedef enum logic [2:0] {PRIME, ARMED, RAMPUP, PAYLOAD, RAMPDOWN, GUARD} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [ADDR_W-1:0]  addr_next;
  logic [7:0]         len_q;
  logic               strobe_d, strobe_edge, consume, fill_bit, in_burst;

  assign strobe_edge   = symbol_input_strobe & ~strobe_d;
  assign is_armed      = (state == ARMED);
  assign in_burst      = (state == RAMPUP) || (state == PAYLOAD) || (state == RAMPDOWN);
  assign sym.sym_ready = consume & sym.sym_valid;

  always_comb begin
    state_next = state;
    count_next = count;
    addr_next  = ramp_addr;
    consume    = 1'b0;
    case (state)
      PRIME:
        if (strobe_edge) begin
          if (count == CNT_W'(PRIME_SYMS - 1)) begin
            state_next = ARMED;
            count_next = '0;
          end else begin
            count_next = count + CNT_W'(1);
          end
        end
      ARMED:
        if (fire_burst) begin
          state_next = RAMPUP;
          addr_next  = '0;
          count_next = '0;
        end
      RAMPUP:
        if (ramp_addr == ADDR_W'(RAMP_LEN - 1)) begin
          state_next = (len_q == 8'd0) ? RAMPDOWN : PAYLOAD;
        end else begin
          addr_next = ramp_addr + ADDR_W'(1);
        end
      // Completion is checked before the strobe, so an edge in the exit clock is not consumed.
      PAYLOAD:
        if (count == CNT_W'(len_q)) begin
          state_next = RAMPDOWN;
          count_next = '0;
        end else if (strobe_edge) begin
          consume    = 1'b1;
          count_next = count + CNT_W'(1);
        end
      RAMPDOWN:
        if (ramp_addr == '0) begin
          state_next = GUARD;
          count_next = '0;
        end else begin
          addr_next = ramp_addr - ADDR_W'(1);
        end
      GUARD:
        if (count == CNT_W'(GUARD_LEN - 1)) begin
          state_next = PRIME;
          count_next = '0;
        end else begin
          count_next = count + CNT_W'(1);
        end
      default: state_next = PRIME;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= PRIME;
      count            <= '0;
      ramp_addr        <= '0;
      strobe_d         <= 1'b0;
      len_q            <= '0;
      current_symbol_o <= 1'b1;
      underrun         <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      ramp_addr <= addr_next;
      strobe_d  <= symbol_input_strobe;
      if (state == ARMED && fire_burst) begin
        len_q    <= burst_len;
        underrun <= 1'b0;
      end
      if (consume && !sym.sym_valid)
        underrun <= 1'b1;
      if (state_next != PAYLOAD)
        current_symbol_o <= 1'b1;
      else if (consume)
        current_symbol_o <= sym.sym_valid ? sym.sym_data : fill_bit;
    end
  end

`ifdef TX_BURST_SEQ_LFSR_FILL_EN
  logic [7:0] lfsr;
  assign fill_bit = lfsr[1];
  always_ff @(posedge clock) begin
    if (!reset)
      lfsr <= 8'h01;
    else if (consume && !sym.sym_valid)
      lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'h8e : 8'h00);
  end
`else
  assign fill_bit = 1'b1;
`endif

  // Stage 1 sees the ROM word for the address registered one clock earlier.
  logic              burst_d1, force_d1, burst_d2;
  logic [MASK_W-1:0] coef_sel;
  logic [PW-1:0]     prod_i, prod_q;
  logic [IQ_W-1:0]   scaled_i, scaled_q;

  always_comb begin
    coef_sel = force_d1 ? {MASK_W{1'b1}} : ramp_coef;
    prod_i   = {{(MASK_W+1){modulator_inphase[IQ_W-1]}}, modulator_inphase}
             * {{(IQ_W+1){1'b0}}, coef_sel};
    prod_q   = {{(MASK_W+1){modulator_quadrature[IQ_W-1]}}, modulator_quadrature}
             * {{(IQ_W+1){1'b0}}, coef_sel};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      burst_d1           <= 1'b0;
      force_d1           <= 1'b0;
      burst_d2           <= 1'b0;
      scaled_i           <= '0;
      scaled_q           <= '0;
      iq_valid           <= 1'b0;
      rfchain_inphase    <= '0;
      rfchain_quadrature <= '0;
    end else begin
      burst_d1           <= in_burst;
      force_d1           <= (state == PAYLOAD);
      burst_d2           <= burst_d1;
      scaled_i           <= IQ_W'(prod_i >> MASK_W);
      scaled_q           <= IQ_W'(prod_q >> MASK_W);
      iq_valid           <= burst_d2;
      rfchain_inphase    <= burst_d2 ? scaled_i : '0;
      rfchain_quadrature <= burst_d2 ? scaled_q : '0;
    end
  end

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// tb/tb_tx_burst_sequencer.sv - directed-vector bench for tx_burst_sequencer
module tb_tx_burst_sequencer;
  localparam int IQ_W = 9, MASK_W = 8, RAMP_LEN = 256, PRIME_SYMS = 4, GUARD_LEN = 1020;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic                   symbol_input_strobe = 1'b0;
  logic                   current_symbol_o;
  logic signed [IQ_W-1:0] modulator_inphase = '0, modulator_quadrature = '0;
  logic signed [IQ_W-1:0] rfchain_inphase, rfchain_quadrature;
  logic                   iq_valid;
  logic [7:0]             ramp_addr;
  logic [MASK_W-1:0]      ramp_coef = '0;
  logic [7:0]             burst_len = '0;
  logic                   fire_burst = 1'b0;
  logic                   is_armed, underrun;

  tx_burst_sequencer_if sym();

  tx_burst_sequencer #(
    .IQ_W(IQ_W), .MASK_W(MASK_W), .RAMP_LEN(RAMP_LEN),
    .PRIME_SYMS(PRIME_SYMS), .GUARD_LEN(GUARD_LEN)
  ) dut (
    .clock(clock), .reset(reset),
    .symbol_input_strobe(symbol_input_strobe), .current_symbol_o(current_symbol_o),
    .modulator_inphase(modulator_inphase), .modulator_quadrature(modulator_quadrature),
    .rfchain_inphase(rfchain_inphase), .rfchain_quadrature(rfchain_quadrature),
    .iq_valid(iq_valid), .ramp_addr(ramp_addr), .ramp_coef(ramp_coef),
    .sym(sym), .burst_len(burst_len), .fire_burst(fire_burst),
    .is_armed(is_armed), .underrun(underrun)
  );

  // Coefficient ROM holding coef = address, one clock read latency.
  always @(posedge clock) ramp_coef <= ramp_addr;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0]  lfsr_m = 8'h01;
  logic [15:0] pat = 16'hb5a3;

  task automatic expect_eq(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic next_fill(output logic b);
`ifdef TX_BURST_SEQ_LFSR_FILL_EN
    b = lfsr_m[1];
    lfsr_m = {1'b0, lfsr_m[7:1]} ^ (lfsr_m[0] ? 8'h8e : 8'h00);
`else
    b = 1'b1;
`endif
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic prime_seq();
    symbol_input_strobe = 1'b1;
    cyc(); cyc(); cyc();
    symbol_input_strobe = 1'b0;
    cyc(); cyc();
    repeat (2) begin
      symbol_input_strobe = 1'b1; cyc();
      symbol_input_strobe = 1'b0; cyc();
    end
    expect_eq("armed_after_3_edges", int'(is_armed), 0);
    symbol_input_strobe = 1'b1; cyc();
    symbol_input_strobe = 1'b0;
    expect_eq("armed_after_4_edges", int'(is_armed), 1);
    cyc();
  endtask

  task automatic run_burst(input int len, input logic [31:0] inv, input int iv, input int qv,
                           input bit fire_in_guard);
    int   p, pulses, want_pulses, coef, s, j;
    bit   exp_v, is_edge;
    logic exp_sym [0:31];
    p = (len > 0) ? 4 * len - 1 : 0;
    pulses = 0;
    want_pulses = 0;
    for (int q = 0; q < len; q++) begin
      if (inv[q]) next_fill(exp_sym[q]);
      else begin
        exp_sym[q] = pat[q];
        want_pulses++;
      end
    end
    modulator_inphase    = IQ_W'(iv);
    modulator_quadrature = IQ_W'(qv);
    burst_len  = 8'(len);
    fire_burst = 1'b1;
    for (int k = 0; k <= 512 + p + GUARD_LEN; k++) begin
      cyc();
      if (k == 0) begin
        fire_burst = 1'b0;
        expect_eq("armed_drop_at_fire", int'(is_armed), 0);
        expect_eq("underrun_cleared_by_fire", int'(underrun), 0);
      end
      exp_v = (k >= 3) && (k < 515 + p);
      expect_eq("iq_valid", int'(iq_valid), int'(exp_v));
      coef = 0;
      if (exp_v) begin
        s = k - 3;
        coef = (s < 256) ? s : (s < 256 + p) ? 255 : 511 + p - s;
      end
      expect_eq("rf_i", int'(rfchain_inphase), exp_v ? ((iv * coef) >>> 8) : 0);
      expect_eq("rf_q", int'(rfchain_quadrature), exp_v ? ((qv * coef) >>> 8) : 0);
      if (k < 256) expect_eq("ramp_addr_up", int'(ramp_addr), k);
      else if (k >= 256 + p && k < 512 + p) expect_eq("ramp_addr_down", int'(ramp_addr), 511 + p - k);
      if (len > 0 && k >= 258 && (k - 258) % 4 == 0 && (k - 258) / 4 < len)
        expect_eq("payload_symbol", int'(current_symbol_o), int'(exp_sym[(k - 258) / 4]));
      if (k == 256 + p) expect_eq("symbol_in_rampdown", int'(current_symbol_o), 1);
      if (k == 512 + p) expect_eq("underrun_after_burst", int'(underrun), int'(inv != 0));
      if (k == 512 + p + GUARD_LEN) expect_eq("not_armed_end_guard", int'(is_armed), 0);

      is_edge = (len > 0) && (k >= 257) && ((k - 257) % 4 == 0) && ((k - 257) / 4 < len);
      j = is_edge ? (k - 257) / 4 : 0;
      symbol_input_strobe = is_edge || k == 100 || k == 266 + p || k == 600 + p;
      sym.sym_valid = is_edge ? !inv[j] : 1'b1;
      sym.sym_data  = is_edge ? pat[j] : 1'b0;
      fire_burst    = fire_in_guard && (k == 700 + p);
      #1;
      expect_eq("sym_ready", int'(sym.sym_ready), int'(is_edge && !inv[j]));
      if (sym.sym_ready) pulses++;
    end
    symbol_input_strobe = 1'b0;
    fire_burst = 1'b0;
    expect_eq("ready_pulse_count", pulses, want_pulses);
  endtask

  initial begin
    sym.sym_data  = 1'b0;
    sym.sym_valid = 1'b0;
    repeat (3) cyc();
    expect_eq("rst_is_armed", int'(is_armed), 0);
    expect_eq("rst_symbol", int'(current_symbol_o), 1);
    expect_eq("rst_iq_valid", int'(iq_valid), 0);
    expect_eq("rst_rf_i", int'(rfchain_inphase), 0);
    expect_eq("rst_rf_q", int'(rfchain_quadrature), 0);
    expect_eq("rst_ramp_addr", int'(ramp_addr), 0);
    expect_eq("rst_underrun", int'(underrun), 0);
    expect_eq("rst_sym_ready", int'(sym.sym_ready), 0);
    reset = 1'b1;
    cyc();

    prime_seq();
    run_burst(13, 32'h0, 255, -100, 1'b0);
    prime_seq();
    run_burst(10, 32'h70, -256, 100, 1'b0);
    prime_seq();
    run_burst(0, 32'h0, 200, 50, 1'b1);

    prime_seq();
    modulator_inphase = IQ_W'(255);
    burst_len  = 8'd13;
    fire_burst = 1'b1;
    for (int k = 0; k <= 262; k++) begin
      cyc();
      fire_burst = 1'b0;
      symbol_input_strobe = (k >= 257) && ((k - 257) % 4 == 0);
      sym.sym_valid = 1'b1;
      sym.sym_data  = 1'b0;
    end
    expect_eq("mid_pre_iq_valid", int'(iq_valid), 1);
    reset = 1'b0;
    symbol_input_strobe = 1'b0;
    cyc();
    expect_eq("mid_rst_iq_valid", int'(iq_valid), 0);
    expect_eq("mid_rst_rf_i", int'(rfchain_inphase), 0);
    expect_eq("mid_rst_rf_q", int'(rfchain_quadrature), 0);
    expect_eq("mid_rst_symbol", int'(current_symbol_o), 1);
    expect_eq("mid_rst_is_armed", int'(is_armed), 0);
    expect_eq("mid_rst_ramp_addr", int'(ramp_addr), 0);
    reset = 1'b1;
    cyc();
    prime_seq();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_burst_sequencer.md
# tx_burst_sequencer

Parametrised GMSK burst sequencer between the symbol source and the GMSK modulator / RF chain. It primes the modulator pipeline, waits armed for a fire command, then runs a burst:
- ramp-up under an amplitude mask;
- a payload of `burst_len` symbols from a valid/ready stream;
- ramp-down, then a guard interval.

The ramp mask is read from an external coefficient ROM, so ramp shape and length are set by parameter and table rather than fixed in RTL.

## Interface
Parameters:
- `IQ_W`, 9: signed I/Q width, in and out.
- `MASK_W`, 8: unsigned ramp coefficient width.
- `RAMP_LEN`, 256: ramp length in samples (clocks); power of two, ≥4.
- `PRIME_SYMS`, 4: modulator strobes consumed while priming.
- `GUARD_LEN`, 1020: idle clocks after ramp-down.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `symbol_input_strobe` in 1: modulator requests next symbol (level; held ≥1 clock).
- `current_symbol_o` out 1: symbol to modulator.
- `modulator_inphase` / `modulator_quadrature` in IQ_W: signed samples from modulator.
- `rfchain_inphase` / `rfchain_quadrature` out IQ_W: masked signed samples.
- `iq_valid` out 1: masked samples valid (PA enable).
- `ramp_addr` out log2(RAMP_LEN): coefficient ROM address.
- `ramp_coef` in MASK_W: ROM data, 1-clock read latency.
- `sym_data` in 1, `sym_valid` in 1, `sym_ready` out 1: payload symbol stream.
- `burst_len` in 8: payload symbol count, sampled at fire.
- `fire_burst` in 1: start burst; acted on only while armed.
- `is_armed` out 1: high only in ARMED.
- `underrun` out 1: sticky; payload symbol requested with `sym_valid`=0.

## Operation
- Strobe edge: first clock `symbol_input_strobe`=1 after being 0. Only edges count; a held strobe counts once.
- States: PRIME → ARMED → RAMPUP → PAYLOAD → RAMPDOWN → GUARD → PRIME.
- PRIME: `current_symbol_o`=1. Count PRIME_SYMS strobe edges, then go to ARMED.
- ARMED: `is_armed`=1. On `fire_burst`=1: latch `burst_len`, clear `underrun`, go to RAMPUP.
- RAMPUP: `ramp_addr` counts 0..RAMP_LEN-1, one per clock, then go to PAYLOAD. `current_symbol_o`=1.
- PAYLOAD: coefficient forced to all-ones. On each strobe edge:
  - If `sym_valid`: `current_symbol_o`←`sym_data`, `sym_ready` pulses 1 clock.
  - Else: `underrun`←1, substitute symbol (see Configuration).
  - Increment count. After `burst_len` edges, go to RAMPDOWN. `burst_len`=0 skips PAYLOAD entirely.
- RAMPDOWN: `ramp_addr` counts RAMP_LEN-1..0, then go to GUARD. `current_symbol_o`=1.
- GUARD: count GUARD_LEN clocks, then go to PRIME.
- Ignored inputs:
  - `fire_burst` outside ARMED.
  - Strobes outside PRIME/PAYLOAD (no `sym_ready` pulse).
  - `sym_valid` outside PAYLOAD.
- Masking arithmetic:
  - Product = signed(iq) × signed({1'b0,coef}), width IQ_W+MASK_W+1.
  - Output = product[IQ_W+MASK_W-1 : MASK_W], truncation with no rounding.
  - Full-scale coefficient therefore attenuates by (2^MASK_W−1)/2^MASK_W.
- Outside the three burst states, `rfchain_*`=0.

## Timing
- Reset (`reset`=0 at an edge) values:
  - State PRIME.
  - All outputs 0, except `current_symbol_o`=1.
  - All counters cleared.
- Reset mid-burst: next cycle `iq_valid`=0, `rfchain_*`=0, and the burst is abandoned.
- Pipeline, 3 clocks from state cycle to output:
  - Clock 0: `ramp_addr` registered.
  - Clock 1: coefficient and I/Q aligned.
  - Clock 2: product registered.
  - Clock 3: `rfchain_*` registered.
- `iq_valid` is the burst-state indicator delayed 3 clocks. It is high exactly 2·RAMP_LEN + (PAYLOAD clocks) clocks per burst.
- `fire_burst` sampled in ARMED → RAMPUP on the next clock. `ramp_addr`=0 that same clock.
- `sym_ready` is asserted in the same clock as the strobe edge. `current_symbol_o` updates on the following clock edge.
- Strobe edge coincident with the PAYLOAD→RAMPDOWN transition clock: not consumed.

## Configuration
- `TX_BURST_SEQ_LFSR_FILL_EN` defined:
  - On underrun the substituted symbol is bit 1 of an 8-bit Galois LFSR, taps 8'h8e, seed 1.
  - The LFSR advances once per substituted symbol and is reset only by `reset`.
- `TX_BURST_SEQ_LFSR_FILL_EN` undefined:
  - The substituted symbol is constant 1.
  - No LFSR logic exists.
- `underrun` behaves identically in both builds.

## Test plan
- Reset, then PRIME_SYMS=4 strobe edges → `is_armed`=1 after the 4th edge. A held strobe counts once.
- Fire with `burst_len`=13, `sym_valid` always 1, input I=+255 constant:
  - Exactly 13 `sym_ready` pulses.
  - Payload `rfchain_inphase`=254.
  - `iq_valid` rises 3 clocks after fire.
- Ramp check, table 0..255, RAMP_LEN=256:
  - `ramp_addr` sequence 0..255, then 255..0.
  - `rfchain` follows coefficient×I>>8 with a 3-clock lag; symmetric up/down.
- `sym_valid`=0 on payload edges 5–7:
  - `underrun`=1 and stays 1.
  - Symbols are 1 (macro off) or the LFSR sequence 0,1,1,… per seed 1 (macro on).
  - `underrun` is cleared by the next fire.
- `burst_len`=0: RAMPUP→RAMPDOWN directly, no `sym_ready` pulse. `fire_burst` during GUARD is ignored.
- `reset`=0 mid-PAYLOAD → next clock `iq_valid`=0, `rfchain`=0, state PRIME, `current_symbol_o`=1.
